// File: rtl/axi_rd_arbiter_pkg.sv
// Shared encodings for the AXI-lite read arbiter: owner bits, arbiter states
// and AXI response codes.
package axi_rd_arbiter_pkg;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCK_IFU = 2'd1,
    LOCK_LSU = 2'd2
  } arb_state_t;

endpackage

// File: rtl/axi_rd_arbiter_fifo.sv
// Order FIFO remembering which master owns each accepted read, one bit per entry.
module rd_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic                     head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap on natural overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin AR arbiter between IFU and LSU sharing one AXI-lite read port,
// with in-order R steering driven by the owner FIFO.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int OT_DEPTH = 4,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ifu_arvalid,
  output logic                        ifu_arready,
  input  logic [ADDR_W-1:0]           ifu_araddr,
  output logic                        ifu_rvalid,
  input  logic                        ifu_rready,
  output logic [1:0]                  ifu_rresp,
  output logic [DATA_W-1:0]           ifu_rdata,
  input  logic                        lsu_arvalid,
  output logic                        lsu_arready,
  input  logic [ADDR_W-1:0]           lsu_araddr,
  output logic                        lsu_rvalid,
  input  logic                        lsu_rready,
  output logic [1:0]                  lsu_rresp,
  output logic [DATA_W-1:0]           lsu_rdata,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  output logic [ADDR_W-1:0]           m_araddr,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  input  logic [1:0]                  m_rresp,
  input  logic [DATA_W-1:0]           m_rdata,
  output logic [$clog2(OT_DEPTH):0]   ot_cnt,
  output logic                        rsp_err
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       last_grant;
  logic       gnt_own;
  logic       gnt_valid;
  logic       ar_hs;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_head;
  logic       r_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= OWN_IFU;
    end else begin
      state <= state_nxt;
      if (ar_hs) begin
        last_grant <= gnt_own;
      end
    end
  end

  // A locked owner keeps the port until it handshakes or withdraws its request
  always_comb begin
    gnt_own   = OWN_IFU;
    gnt_valid = 1'b0;
    state_nxt = state;
    case (state)
      LOCK_IFU: begin
        gnt_own   = OWN_IFU;
        gnt_valid = ifu_arvalid;
      end
      LOCK_LSU: begin
        gnt_own   = OWN_LSU;
        gnt_valid = lsu_arvalid;
      end
      default: begin
        if (ifu_arvalid && lsu_arvalid) begin
          gnt_own = ~last_grant;
        end else if (lsu_arvalid) begin
          gnt_own = OWN_LSU;
        end
        gnt_valid = ifu_arvalid | lsu_arvalid;
      end
    endcase

    m_arvalid   = gnt_valid & ~fifo_full;
    ar_hs       = m_arvalid & m_arready;
    ifu_arready = ar_hs & (gnt_own == OWN_IFU);
    lsu_arready = ar_hs & (gnt_own == OWN_LSU);
    m_araddr    = (m_arvalid && gnt_own == OWN_LSU) ? lsu_araddr : ifu_araddr;

    if (ar_hs) begin
      state_nxt = IDLE;
    end else if (state == IDLE) begin
      if (m_arvalid) begin
        state_nxt = (gnt_own == OWN_LSU) ? LOCK_LSU : LOCK_IFU;
      end
    end else if (!gnt_valid) begin
      state_nxt = IDLE;
    end
  end

  // With nothing outstanding, stray beats are accepted and dropped
  always_comb begin
    ifu_rvalid = 1'b0;
    lsu_rvalid = 1'b0;
    m_rready   = m_rvalid;
    if (!fifo_empty) begin
      ifu_rvalid = m_rvalid & (fifo_head == OWN_IFU);
      lsu_rvalid = m_rvalid & (fifo_head == OWN_LSU);
      m_rready   = (fifo_head == OWN_LSU) ? lsu_rready : ifu_rready;
    end
    r_pop = m_rvalid & m_rready & ~fifo_empty;
  end

  assign ifu_rdata = m_rdata;
  assign lsu_rdata = m_rdata;
  assign ifu_rresp = m_rresp;
  assign lsu_rresp = m_rresp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (m_rvalid && fifo_empty) begin
      rsp_err <= 1'b1;
    end
  end

  rd_order_fifo #(
    .DEPTH (OT_DEPTH)
  ) u_order_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ar_hs),
    .din   (gnt_own),
    .pop   (r_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head),
    .count (ot_cnt)
  );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed vector table followed by random traffic
// checked against a queue-based model of the arbitration and ordering rules.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam int OT = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [AW-1:0] IFU_A = 64'h0000_0000_8000_0000;
  localparam logic [AW-1:0] LSU_A = 64'h0000_0000_4000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [AW-1:0] ifu_araddr;
  logic [1:0]    ifu_rresp;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [AW-1:0] lsu_araddr;
  logic [1:0]    lsu_rresp;
  logic [DW-1:0] lsu_rdata;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0] m_araddr;
  logic [1:0]    m_rresp;
  logic [DW-1:0] m_rdata;
  logic [2:0]    ot_cnt;
  logic          rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.OT_DEPTH(OT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rresp(lsu_rresp), .lsu_rdata(lsu_rdata),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .ot_cnt(ot_cnt), .rsp_err(rsp_err)
  );

  // stim = {ifu_arvalid, lsu_arvalid, m_arready, m_rvalid, ifu_rready, lsu_rready}
  // expo = {m_arvalid, ifu_arready, lsu_arready, addr_is_lsu, ifu_rvalid, lsu_rvalid, m_rready}
  typedef struct packed {
    logic [5:0] stim;
    logic [6:0] expo;
    logic [2:0] cnt;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  // Model: owners of accepted reads in order, a pending lock, and the last winner
  bit mdl_q[$];
  bit mdl_lock_vld;
  bit mdl_lock_own;
  bit mdl_last;
  bit mdl_err;
  bit exp_mav, exp_iar, exp_lar, exp_irv, exp_lrv, exp_mrr, exp_cand;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    mdl_q.delete();
    mdl_lock_vld = 0;
    mdl_lock_own = 0;
    mdl_last     = 0;
    mdl_err      = 0;
  endtask

  task automatic modelComb();
    bit full, cv;
    full = (mdl_q.size() == OT);
    cv = 0;
    exp_cand = 0;
    if (mdl_lock_vld) begin
      exp_cand = mdl_lock_own;
      cv = mdl_lock_own ? lsu_arvalid : ifu_arvalid;
    end else if (ifu_arvalid && lsu_arvalid) begin
      exp_cand = !mdl_last;
      cv = 1;
    end else if (ifu_arvalid || lsu_arvalid) begin
      exp_cand = lsu_arvalid;
      cv = 1;
    end
    exp_mav = cv && !full;
    exp_iar = exp_mav && m_arready && !exp_cand;
    exp_lar = exp_mav && m_arready && exp_cand;
    if (mdl_q.size() == 0) begin
      exp_irv = 0;
      exp_lrv = 0;
      exp_mrr = m_rvalid;
    end else begin
      exp_irv = m_rvalid && !mdl_q[0];
      exp_lrv = m_rvalid && mdl_q[0];
      exp_mrr = mdl_q[0] ? lsu_rready : ifu_rready;
    end
  endtask

  task automatic modelUpdate();
    bit was_empty, cur_valid;
    was_empty = (mdl_q.size() == 0);
    cur_valid = mdl_lock_own ? lsu_arvalid : ifu_arvalid;
    if (was_empty && m_rvalid) mdl_err = 1;
    if (!was_empty && m_rvalid && exp_mrr) void'(mdl_q.pop_front());
    if (exp_mav && m_arready) begin
      mdl_q.push_back(exp_cand);
      mdl_last = exp_cand;
      mdl_lock_vld = 0;
    end else if (mdl_lock_vld && !cur_valid) begin
      mdl_lock_vld = 0;
    end else if (!mdl_lock_vld && exp_mav) begin
      mdl_lock_vld = 1;
      mdl_lock_own = exp_cand;
    end
  endtask

  task automatic applyStimulus(input logic [5:0] stim);
    {ifu_arvalid, lsu_arvalid, m_arready, m_rvalid, ifu_rready, lsu_rready} = stim;
  endtask

  task automatic checkOutput();
    check("ar_handshake", {m_arvalid, ifu_arready, lsu_arready}, {exp_mav, exp_iar, exp_lar});
    if (exp_mav) check("araddr", m_araddr, exp_cand ? lsu_araddr : ifu_araddr);
    check("r_steer", {ifu_rvalid, lsu_rvalid, m_rready}, {exp_irv, exp_lrv, exp_mrr});
    check("rdata", {ifu_rdata, lsu_rdata}, {m_rdata, m_rdata});
    check("rresp", {ifu_rresp, lsu_rresp}, {m_rresp, m_rresp});
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1
  task automatic runCycle(input bit use_tbl, input vec_t v);
    #4;
    modelComb();
    checkOutput();
    if (use_tbl) begin
      check("tbl_hs", {m_arvalid, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, m_rready},
            {v.expo[6:4], v.expo[2:0]});
      if (v.expo[6]) check("tbl_araddr", m_araddr, v.expo[3] ? LSU_A : IFU_A);
    end
    @(posedge clk);
    modelUpdate();
    #1;
    check("ot_cnt", ot_cnt, mdl_q.size());
    check("rsp_err", rsp_err, mdl_err);
    if (use_tbl) begin
      check("tbl_ot_cnt", ot_cnt, v.cnt);
      check("tbl_rsp_err", rsp_err, v.err);
    end
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    applyStimulus(6'b0);
    ifu_araddr = IFU_A;
    lsu_araddr = LSU_A;
    m_rdata    = 64'h1122334455667788;
    m_rresp    = OKAY;
    modelReset();

    tbl = '{
      '{6'b000000, 7'b0000000, 3'd0, 1'b0},  // idle
      '{6'b101000, 7'b1100000, 3'd1, 1'b0},  // single IFU read accepted
      '{6'b000110, 7'b0000101, 3'd0, 1'b0},  // its beat returns to IFU
      '{6'b111000, 7'b1011000, 3'd1, 1'b0},  // both request: LSU first
      '{6'b111000, 7'b1100000, 3'd2, 1'b0},  // then IFU
      '{6'b111000, 7'b1011000, 3'd3, 1'b0},  // LSU
      '{6'b111000, 7'b1100000, 3'd4, 1'b0},  // IFU, now full
      '{6'b111111, 7'b0000011, 3'd3, 1'b0},  // full: blocked even while popping
      '{6'b111000, 7'b1011000, 3'd4, 1'b0},  // accepted next cycle
      '{6'b000111, 7'b0000101, 3'd3, 1'b0},  // beats in order: I
      '{6'b000111, 7'b0000011, 3'd2, 1'b0},  // L
      '{6'b000111, 7'b0000101, 3'd1, 1'b0},  // I
      '{6'b000111, 7'b0000011, 3'd0, 1'b0},  // L
      '{6'b100000, 7'b1000000, 3'd0, 1'b0},  // IFU granted, stalled -> lock
      '{6'b110000, 7'b1000000, 3'd0, 1'b0},  // LSU waits behind lock
      '{6'b110000, 7'b1000000, 3'd0, 1'b0},
      '{6'b111000, 7'b1100000, 3'd1, 1'b0},  // 4th cycle: IFU handshake
      '{6'b111000, 7'b1011000, 3'd2, 1'b0},  // then LSU
      '{6'b100000, 7'b1000000, 3'd2, 1'b0},  // IFU locks again
      '{6'b010000, 7'b0000000, 3'd2, 1'b0},  // IFU withdraws: no push
      '{6'b011000, 7'b1011000, 3'd3, 1'b0},  // LSU granted from IDLE
      '{6'b000101, 7'b0000100, 3'd3, 1'b0},  // IFU head back-pressures
      '{6'b000111, 7'b0000101, 3'd2, 1'b0},
      '{6'b000111, 7'b0000011, 3'd1, 1'b0},
      '{6'b000111, 7'b0000011, 3'd0, 1'b0},
      '{6'b000100, 7'b0000001, 3'd0, 1'b1},  // spurious beat drained, error set
      '{6'b000000, 7'b0000000, 3'd0, 1'b1}   // error stays sticky
    };

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {m_arvalid, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, m_rready}, 6'b0);
    check("reset_ot_cnt", ot_cnt, 3'd0);
    check("reset_rsp_err", rsp_err, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    foreach (tbl[i]) begin
      v = tbl[i];
      applyStimulus(v.stim);
      runCycle(1'b1, v);
    end

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      applyStimulus({$urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0});
      ifu_araddr = {$urandom, $urandom};
      lsu_araddr = {$urandom, $urandom};
      m_rdata    = {$urandom, $urandom};
      m_rresp    = $urandom_range(0, 1) ? SLVERR : OKAY;
      runCycle(1'b0, v);
    end

    $display("[TB] asynchronous reset mid-transfer");
    applyStimulus(6'b111000);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    check("midreset_ot_cnt", ot_cnt, 3'd0);
    check("midreset_rsp_err", rsp_err, 1'b0);
    check("midreset_rready", m_rready, 1'b0);
    applyStimulus(6'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      applyStimulus({$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1});
      runCycle(1'b0, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
